// File: rtl/swu_frame_writer_if.sv
// Bundles the sample stream, frame handshake and frame read port of the
// sliding-window-unit sample store writer.
interface swu_frame_writer_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic             frame_done;
    logic             frame_release;
    logic [AW-1:0]    wr_word_cnt;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output in_valid, in_data, frame_release, rd_en, rd_addr,
        input  in_ready, frame_done, wr_word_cnt, rd_data
    );

    modport slave (
        input  in_valid, in_data, frame_release, rd_en, rd_addr,
        output in_ready, frame_done, wr_word_cnt, rd_data
    );
endinterface

// File: rtl/swu_frame_writer.sv
// Packs a 1-bit sample stream LSB-first into words and stores one frame of
// DEPTH words, holding it stable until the consumer releases it.
module swu_frame_writer #(
    parameter int DEPTH = 29,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    swu_frame_writer_if.slave bus
);
    localparam int BW = $clog2(WIDTH);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    // The final bit of a word goes straight to memory, so only WIDTH-1 bits are held.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [AW-1:0]    wr_word_cnt_q, wr_word_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             rd_zero_q, rd_zero_d;
    logic [WIDTH-1:0] mem_rd_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             hs;
    logic             word_last;
    logic             wr_en;
    logic [WIDTH-1:0] wr_word;

    assign bus.in_ready    = (state_q == ST_FILL);
    assign bus.frame_done  = frame_done_q;
    assign bus.wr_word_cnt = wr_word_cnt_q;
    assign bus.rd_data     = rd_zero_q ? '0 : mem_rd_q;

    assign hs        = bus.in_valid & (state_q == ST_FILL);
    assign word_last = (bit_cnt_q == BW'(WIDTH - 1));
    assign wr_en     = hs & word_last;
    assign wr_word   = {bus.in_data, sr_q};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        wr_word_cnt_d = wr_word_cnt_q;
        frame_done_d  = frame_done_q;
        rd_zero_d     = rd_zero_q;

        case (state_q)
            ST_FILL: begin
                if (hs) begin
                    if (word_last) begin
                        bit_cnt_d     = '0;
                        sr_d          = '0;
                        wr_word_cnt_d = wr_word_cnt_q + AW'(1);
                        if (wr_word_cnt_q == AW'(DEPTH - 1)) begin
                            state_d      = ST_FULL;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        sr_d[bit_cnt_q] = bus.in_data;
                        bit_cnt_d       = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (bus.frame_release) begin
                    state_d       = ST_FILL;
                    frame_done_d  = 1'b0;
                    wr_word_cnt_d = '0;
                    bit_cnt_d     = '0;
                    sr_d          = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (bus.rd_en) begin
            rd_zero_d = (32'(bus.rd_addr) >= DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            bit_cnt_q     <= '0;
            sr_q          <= '0;
            wr_word_cnt_q <= '0;
            frame_done_q  <= 1'b0;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            wr_word_cnt_q <= wr_word_cnt_d;
            frame_done_q  <= frame_done_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    // Storage is never reset; out-of-range reads are masked by rd_zero_q.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_word_cnt_q] <= wr_word;
        end
        if (bus.rd_en) begin
            mem_rd_q <= mem[bus.rd_addr];
        end
    end
endmodule

// File: tb/tb_swu_frame_writer.sv
// Directed bench for swu_frame_writer: frame fill, gapped input, frozen FULL
// state, read/write collision, mid-frame reset and ignored release in FILL.
module tb_swu_frame_writer;
    localparam int DEPTH = 29;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NBITS = DEPTH * WIDTH;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] rdv;

    swu_frame_writer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    swu_frame_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_mod3(input int k);
        return (k % 3) == 0;
    endfunction

    function automatic logic [31:0] word_mod3(input int w);
        case (w % 3)
            0:       return 32'h49249249;
            1:       return 32'h92492492;
            default: return 32'h24924924;
        endcase
    endfunction

    task automatic send(input logic b);
        @(negedge clk);
        bus.rd_en    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = addr;
        @(posedge clk);
        #1;
        data = bus.rd_data;
    endtask

    task automatic release_pulse();
        @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.rd_en         = 1'b0;
        bus.frame_release = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.frame_release = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = 1'b0;
        bus.frame_release = 1'b0;
        bus.rd_en         = 1'b0;
        bus.rd_addr       = '0;

        repeat (3) @(posedge clk);
        #1;
        $display("reset: in_ready=%b frame_done=%b cnt=%0d rd_data=%h",
                 bus.in_ready, bus.frame_done, bus.wr_word_cnt, bus.rd_data);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_wr_cnt", 32'(bus.wr_word_cnt), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: continuous stream, bit k = (k mod 3 == 0)
        for (int k = 0; k < NBITS; k++) begin
            send(bit_mod3(k));
            if (k == NBITS - 2) check("f1_done_early", 32'(bus.frame_done), 32'd0);
        end
        $display("frame1: frame_done=%b in_ready=%b cnt=%0d", bus.frame_done, bus.in_ready, bus.wr_word_cnt);
        check("f1_done", 32'(bus.frame_done), 32'd1);
        check("f1_in_ready", 32'(bus.in_ready), 32'd0);
        check("f1_wr_cnt", 32'(bus.wr_word_cnt), 32'd29);
        rd(5'd0, rdv);  $display("f1 rd 0 = %h", rdv);  check("f1_word0", rdv, 32'h49249249);
        rd(5'd1, rdv);  $display("f1 rd 1 = %h", rdv);  check("f1_word1", rdv, 32'h92492492);
        rd(5'd2, rdv);  $display("f1 rd 2 = %h", rdv);  check("f1_word2", rdv, 32'h24924924);
        rd(5'd28, rdv); $display("f1 rd 28 = %h", rdv); check("f1_word28", rdv, 32'h92492492);

        // FULL: 100 cycles of offered ones must not disturb anything
        for (int i = 0; i < 100; i++) send(1'b1);
        $display("full hold: in_ready=%b cnt=%0d", bus.in_ready, bus.wr_word_cnt);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_wr_cnt", 32'(bus.wr_word_cnt), 32'd29);
        rd(5'd0, rdv);  $display("full rd 0 = %h", rdv);  check("full_word0", rdv, 32'h49249249);
        rd(5'd28, rdv); $display("full rd 28 = %h", rdv); check("full_word28", rdv, 32'h92492492);

        release_pulse();
        #1;
        $display("release: in_ready=%b frame_done=%b cnt=%0d", bus.in_ready, bus.frame_done, bus.wr_word_cnt);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_frame_done", 32'(bus.frame_done), 32'd0);
        check("rel_wr_cnt", 32'(bus.wr_word_cnt), 32'd0);

        // Frame 2: all ones, with read/write collision on word 3
        for (int k = 0; k < NBITS; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 1'b1;
            bus.rd_en    = (k >= 127 && k <= 129);
            bus.rd_addr  = (k == 129) ? 5'd31 : 5'd3;
            @(posedge clk);
            #1;
            if (k == 127) begin
                $display("collide rd 3 = %h cnt=%0d", bus.rd_data, bus.wr_word_cnt);
                check("coll_old_word3", bus.rd_data, 32'h49249249);
                check("coll_wr_cnt", 32'(bus.wr_word_cnt), 32'd4);
            end
            if (k == 128) begin
                $display("next rd 3 = %h", bus.rd_data);
                check("coll_new_word3", bus.rd_data, 32'hFFFFFFFF);
            end
            if (k == 129) begin
                $display("rd 31 = %h", bus.rd_data);
                check("oob_addr31", bus.rd_data, 32'h00000000);
            end
        end
        check("f2_done", 32'(bus.frame_done), 32'd1);
        rd(5'd28, rdv); $display("f2 rd 28 = %h", rdv); check("f2_word28", rdv, 32'hFFFFFFFF);
        rd(5'd0, rdv);  $display("f2 rd 0 = %h", rdv);  check("f2_word0", rdv, 32'hFFFFFFFF);

        // Frame 3: mod-3 stream with in_valid toggling, inverted in_data on idle cycles
        release_pulse();
        for (int c = 0; c < 2 * NBITS; c++) begin
            @(negedge clk);
            bus.rd_en    = 1'b0;
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = (c % 2 == 0) ? bit_mod3(c / 2) : ~bit_mod3(c / 2 + 1);
            @(posedge clk);
            #1;
            if ((c + 1) % 64 == 0) begin
                $display("gap c=%0d cnt=%0d", c + 1, bus.wr_word_cnt);
                check("gap_wr_cnt", 32'(bus.wr_word_cnt), 32'((c + 1) / 64));
            end
            if (c == 2 * NBITS - 3) check("gap_done_early", 32'(bus.frame_done), 32'd0);
            if (c == 2 * NBITS - 2) check("gap_done", 32'(bus.frame_done), 32'd1);
        end
        for (int w = 0; w < DEPTH; w += 9) begin
            rd(AW'(w), rdv);
            $display("f3 rd %0d = %h", w, rdv);
            check("gap_word", rdv, word_mod3(w));
        end

        // Reset after 500 bits, then an alternating frame
        release_pulse();
        for (int k = 0; k < 500; k++) send(1'b1);
        check("pre_rst_wr_cnt", 32'(bus.wr_word_cnt), 32'd15);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        @(posedge clk);
        #1;
        $display("mid reset: frame_done=%b cnt=%0d in_ready=%b", bus.frame_done, bus.wr_word_cnt, bus.in_ready);
        check("mrst_frame_done", 32'(bus.frame_done), 32'd0);
        check("mrst_wr_cnt", 32'(bus.wr_word_cnt), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < NBITS; k++) begin
            send(k % 2 == 0);
            if (k == NBITS - 2) check("alt_done_early", 32'(bus.frame_done), 32'd0);
        end
        check("alt_done", 32'(bus.frame_done), 32'd1);
        for (int w = 0; w < DEPTH; w++) begin
            rd(AW'(w), rdv);
            $display("alt rd %0d = %h", w, rdv);
            check("alt_word", rdv, 32'h55555555);
        end

        // Release during FILL must be ignored
        release_pulse();
        for (int k = 0; k < 40; k++) send(1'b0);
        @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.frame_release = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_release = 1'b0;
        $display("fill release: cnt=%0d in_ready=%b frame_done=%b", bus.wr_word_cnt, bus.in_ready, bus.frame_done);
        check("fillrel_wr_cnt", 32'(bus.wr_word_cnt), 32'd1);
        check("fillrel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 887; k++) send(1'b0);
        check("fillrel_done_early", 32'(bus.frame_done), 32'd0);
        send(1'b0);
        $display("fill release frame: frame_done=%b", bus.frame_done);
        check("fillrel_done", 32'(bus.frame_done), 32'd1);
        rd(5'd0, rdv); $display("fz rd 0 = %h", rdv); check("fz_word0", rdv, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/swu_frame_writer.md
# swu_frame_writer

Write side of the sliding-window-unit sample store. Accepts a serial stream of binarized ECG samples (1 bit per handshake), packs them LSB-first into 32-bit words, and writes one full frame of DEPTH words into an internal memory. Downstream SWU logic reads the frame through a synchronous enable/addr/data port with one-cycle latency. A frame is held stable until the consumer releases it.

## Interface
- DEPTH, 29, words per frame (frame = DEPTH*WIDTH bits)
- WIDTH, 32, bits per word
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  sample valid
- in_data  in  1  binarized sample bit
- in_ready  out  1  writer accepts a sample this cycle
- frame_done  out  1  full frame stored, memory stable
- frame_release  in  1  one-cycle pulse: consumer finished, start next frame
- wr_word_cnt  out  AW  words completed in current frame
- rd_en  in  1  read enable
- rd_addr  in  AW  read word address
- rd_data  out  WIDTH  read data, registered

## Operation
- States: FILL, FULL. Reset -> FILL.
- in_ready = (state == FILL); decoded directly from state register, no dependence on in_valid.
- Handshake = in_valid & in_ready. Only handshakes advance the packer; in_data ignored otherwise.
- Packer: shift register sr[WIDTH-1:0], bit counter bit_cnt (0..WIDTH-1). On handshake sr[bit_cnt] <= in_data, bit_cnt++ (first bit -> word bit 0).
- On handshake with bit_cnt == WIDTH-1: memory[wr_word_cnt] <= {in_data, sr[WIDTH-2:0]} on that same edge; bit_cnt <= 0; sr cleared; wr_word_cnt++.
- If that word is word DEPTH-1: wr_word_cnt <= 0 is NOT done; wr_word_cnt saturates at DEPTH, state -> FULL, frame_done <= 1.
- FULL: in_ready = 0, no writes, memory contents frozen. frame_release -> FILL, frame_done <= 0, wr_word_cnt <= 0, bit_cnt <= 0.
- frame_release in FILL: ignored, no effect on counters.
- Read port independent of state: on rd_en, rd_data <= memory[rd_addr]; rd_addr >= DEPTH returns 0. rd_en low holds rd_data.
- Read and write to the same address on the same edge: rd_data returns the pre-write (old) contents.
- Memory contents are not reset; before the first complete frame, reads of unwritten words return undefined data. Bench must not check them.
- Reset mid-frame (rst_n low at any edge): partial word and counters discarded, state FILL, words already written remain in memory but frame_done stays 0 until a full new frame is stored.

## Timing
- Reset values (edge with rst_n = 0): state FILL, bit_cnt 0, sr 0, wr_word_cnt 0, frame_done 0, rd_data 0; in_ready reads 1 from the first cycle after reset.
- Sample throughput: 1 bit per cycle with in_valid held high; one frame = DEPTH*WIDTH = 928 handshake cycles.
- Word write completes on the edge of its WIDTH-th handshake; readable by rd_en on the next cycle (data on rd_data one cycle after that).
- frame_done and in_ready = 0 both visible in the cycle after the 928th handshake edge; no 929th bit is accepted.
- frame_release sampled at edge N -> in_ready = 1, frame_done = 0 in cycle N+1.
- Read latency: exactly 1 cycle from rd_en edge to rd_data.
- in_valid gaps of any length pause the packer with no loss of state.

## Test plan
- Reset then 928 bits with in_valid held high, bit k = (k mod 3 == 0) -> frame_done rises exactly one cycle after handshake 928; reading addr 0 returns 0x49249249; in_ready = 0 while FULL.
- Same stream with in_valid toggling 1/0 every cycle -> identical memory contents and frame_done after 1856 cycles; wr_word_cnt steps every 64 cycles.
- While FULL, drive in_valid = 1 with in_data = 1 for 100 cycles -> memory unchanged; then frame_release pulse -> in_ready = 1 next cycle, wr_word_cnt = 0, next frame of all-ones gives 0xFFFFFFFF at addr 28.
- During frame 2, rd_en with rd_addr = 3 on the edge word 3 is written -> rd_data equals frame-1 word 3; read next cycle returns new word; rd_addr = 31 returns 0x00000000.
- Reset asserted after 500 bits -> frame_done 0, wr_word_cnt 0; then 928 bits of alternating 1,0 -> every word reads 0x55555555.
- frame_release pulsed during FILL after 40 bits -> no effect; frame_done rises after 888 further handshakes.
